// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with packet-level locking (SA stage).
// Grants are combinational; the crossbar select/valid for the ST stage are registered.
module switch_allocator #(
    parameter  int INPUT_NUM  = 5,
    parameter  int OUTPUT_NUM = 5,
    localparam int SEL_SIZE   = (INPUT_NUM  > 1) ? $clog2(INPUT_NUM)  : 1,
    localparam int PORT_SIZE  = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [INPUT_NUM-1:0]                  request_i,
    input  logic [INPUT_NUM-1:0][PORT_SIZE-1:0]   out_port_i,
    input  logic [INPUT_NUM-1:0]                  tail_i,
    input  logic [OUTPUT_NUM-1:0]                 ready_i,
    output logic [INPUT_NUM-1:0]                  grant_o,
    output logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]   sel_o,
    output logic [OUTPUT_NUM-1:0]                 valid_o
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                                r_state [OUTPUT_NUM];
    logic   [OUTPUT_NUM-1:0][SEL_SIZE-1:0] r_ptr;
    logic   [OUTPUT_NUM-1:0][SEL_SIZE-1:0] r_owner;
    logic   [OUTPUT_NUM-1:0][SEL_SIZE-1:0] r_sel;
    logic   [OUTPUT_NUM-1:0]               r_valid;

    state_t                                w_state_nxt [OUTPUT_NUM];
    logic   [OUTPUT_NUM-1:0][SEL_SIZE-1:0] w_ptr_nxt;
    logic   [OUTPUT_NUM-1:0][SEL_SIZE-1:0] w_owner_nxt;
    logic   [OUTPUT_NUM-1:0][INPUT_NUM-1:0] w_cand;
    logic   [OUTPUT_NUM-1:0][SEL_SIZE:0]   w_pick;
    logic   [OUTPUT_NUM-1:0]               w_gnt;
    logic   [OUTPUT_NUM-1:0][SEL_SIZE-1:0] w_win;

    function automatic logic [SEL_SIZE-1:0] wrap_inc(input logic [SEL_SIZE-1:0] idx);
        return (idx == SEL_SIZE'(INPUT_NUM-1)) ? '0 : idx + 1'b1;
    endfunction

    // Returns {found, winner}: first set bit at or after ptr, wrapping at INPUT_NUM-1.
    function automatic logic [SEL_SIZE:0] rr_pick(input logic [INPUT_NUM-1:0] cand,
                                                  input logic [SEL_SIZE-1:0]  ptr);
        logic [SEL_SIZE-1:0] idx;
        logic [SEL_SIZE-1:0] win;
        logic                found;
        idx   = ptr;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < INPUT_NUM; k++) begin
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = wrap_inc(idx);
        end
        return {found, win};
    endfunction

    always_comb begin
        w_cand = '0;
        w_pick = '0;
        for (int j = 0; j < OUTPUT_NUM; j++) begin
            for (int i = 0; i < INPUT_NUM; i++)
                w_cand[j][i] = request_i[i] && (out_port_i[i] == PORT_SIZE'(j));
            w_pick[j] = rr_pick(w_cand[j], r_ptr[j]);
        end
    end

    always_comb begin
        w_gnt       = '0;
        w_win       = '0;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        for (int j = 0; j < OUTPUT_NUM; j++) begin
            w_state_nxt[j] = r_state[j];
            if (ready_i[j]) begin
                if (r_state[j] == LOCKED) begin
                    if (w_cand[j][r_owner[j]]) begin
                        w_gnt[j] = 1'b1;
                        w_win[j] = r_owner[j];
                        if (tail_i[r_owner[j]]) begin
                            w_state_nxt[j] = IDLE;
                            w_ptr_nxt[j]   = wrap_inc(r_owner[j]);
                        end
                    end
                end else if (w_pick[j][SEL_SIZE]) begin
                    w_gnt[j]     = 1'b1;
                    w_win[j]     = w_pick[j][SEL_SIZE-1:0];
                    w_ptr_nxt[j] = wrap_inc(w_pick[j][SEL_SIZE-1:0]);
                    if (!tail_i[w_pick[j][SEL_SIZE-1:0]]) begin
                        w_state_nxt[j] = LOCKED;
                        w_owner_nxt[j] = w_pick[j][SEL_SIZE-1:0];
                    end
                end
            end
        end
    end

    // Inputs target one output each, so OR-ing per-output grants never collides.
    always_comb begin
        grant_o = '0;
        if (rst) begin
            for (int j = 0; j < OUTPUT_NUM; j++)
                if (w_gnt[j]) grant_o[w_win[j]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < OUTPUT_NUM; j++) r_state[j] <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_sel   <= '0;
            r_valid <= '0;
        end else begin
            for (int j = 0; j < OUTPUT_NUM; j++) begin
                r_state[j] <= w_state_nxt[j];
                if (w_gnt[j]) r_sel[j] <= w_win[j];
            end
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_valid <= w_gnt;
        end
    end

    assign sel_o   = r_sel;
    assign valid_o = r_valid;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: reset, round-robin, locking, back-pressure,
// parallel outputs, pointer wrap and mid-packet reset.
module tb_switch_allocator;

    localparam int IN  = 5;
    localparam int OUT = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [IN-1:0]          request_i;
    logic [IN-1:0][2:0]     out_port_i;
    logic [IN-1:0]          tail_i;
    logic [OUT-1:0]         ready_i;
    logic [IN-1:0]          grant_o;
    logic [OUT-1:0][2:0]    sel_o;
    logic [OUT-1:0]         valid_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    switch_allocator #(.INPUT_NUM(IN), .OUTPUT_NUM(OUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .request_i  (request_i),
        .out_port_i (out_port_i),
        .tail_i     (tail_i),
        .ready_i    (ready_i),
        .grant_o    (grant_o),
        .sel_o      (sel_o),
        .valid_o    (valid_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] all_to(input logic [2:0] p);
        return {5{p}};
    endfunction

    task automatic drive(input logic [4:0] req, input logic [4:0] tl,
                         input logic [4:0] rdy, input logic [14:0] ports);
        request_i  = req;
        tail_i     = tl;
        ready_i    = rdy;
        out_port_i = ports;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(5'b0, 5'b0, 5'b11111, 15'b0);
        tick();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with all inputs requesting
        rst = 1'b0;
        drive(5'b11111, 5'b11111, 5'b11111, all_to(3'd0));
        check("rst_grant", grant_o, 5'b00000);
        check("rst_valid", valid_o, 5'b00000);
        check("rst_sel", sel_o, 15'b0);
        tick();
        check("rst_grant_edge", grant_o, 5'b00000);
        check("rst_valid_edge", valid_o, 5'b00000);
        rst = 1'b1;
        #1;
        check("post_rst_first", grant_o, 5'b00001);
        tick();
        check("post_rst_valid", valid_o, 5'b00001);
        check("post_rst_sel0", sel_o[0], 3'd0);
        check("post_rst_second", grant_o, 5'b00010);

        // Round-robin among inputs 0,1,2 to output 3
        do_reset();
        drive(5'b00111, 5'b00111, 5'b11111, all_to(3'd3));
        check("rr_g0", grant_o, 5'b00001);
        tick();
        check("rr_v0", valid_o, 5'b01000);
        check("rr_s0", sel_o[3], 3'd0);
        check("rr_g1", grant_o, 5'b00010);
        tick();
        check("rr_s1", sel_o[3], 3'd1);
        check("rr_g2", grant_o, 5'b00100);
        tick();
        check("rr_s2", sel_o[3], 3'd2);
        check("rr_g3", grant_o, 5'b00001);
        tick();
        check("rr_s3", sel_o[3], 3'd0);
        check("rr_v3", valid_o, 5'b01000);

        // Lock: input 1 three-flit packet to output 0, input 4 waits
        do_reset();
        drive(5'b10010, 5'b10000, 5'b11111, all_to(3'd0));
        check("lk_g0", grant_o, 5'b00010);
        tick();
        check("lk_v0", valid_o, 5'b00001);
        check("lk_s0", sel_o[0], 3'd1);
        check("lk_g1", grant_o, 5'b00010);
        tick();
        check("lk_v1", valid_o, 5'b00001);
        drive(5'b10010, 5'b10010, 5'b11111, all_to(3'd0));
        check("lk_g2", grant_o, 5'b00010);
        tick();
        check("lk_v2", valid_o, 5'b00001);
        check("lk_s2", sel_o[0], 3'd1);
        drive(5'b10000, 5'b10000, 5'b11111, all_to(3'd0));
        check("lk_g3", grant_o, 5'b10000);
        tick();
        check("lk_v3", valid_o, 5'b00001);
        check("lk_s3", sel_o[0], 3'd4);
        drive(5'b00000, 5'b00000, 5'b11111, all_to(3'd0));
        check("lk_g4", grant_o, 5'b00000);
        tick();
        check("lk_v4", valid_o, 5'b00000);
        check("lk_s4_hold", sel_o[0], 3'd4);

        // Back-pressure on output 2 during a packet locked by input 3
        do_reset();
        drive(5'b01000, 5'b00000, 5'b11111, all_to(3'd2));
        check("bp_g0", grant_o, 5'b01000);
        tick();
        check("bp_v0", valid_o, 5'b00100);
        check("bp_s0", sel_o[2], 3'd3);
        for (int c = 0; c < 3; c++) begin
            drive(5'b01001, 5'b00001, 5'b11011, all_to(3'd2));
            check("bp_stall_g", grant_o, 5'b00000);
            tick();
            check("bp_stall_v", valid_o, 5'b00000);
            check("bp_stall_s", sel_o[2], 3'd3);
        end
        drive(5'b01001, 5'b00001, 5'b11111, all_to(3'd2));
        check("bp_resume_g", grant_o, 5'b01000);
        tick();
        check("bp_resume_v", valid_o, 5'b00100);
        drive(5'b01001, 5'b01001, 5'b11111, all_to(3'd2));
        check("bp_tail_g", grant_o, 5'b01000);
        tick();
        drive(5'b00001, 5'b00001, 5'b11111, all_to(3'd2));
        check("bp_next_g", grant_o, 5'b00001);
        tick();
        check("bp_next_s", sel_o[2], 3'd0);
        check("bp_next_v", valid_o, 5'b00100);

        // Parallel: input i to output 4-i, then an out-of-range port
        do_reset();
        drive(5'b11111, 5'b11111, 5'b11111, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        check("par_g", grant_o, 5'b11111);
        tick();
        check("par_v", valid_o, 5'b11111);
        for (int j = 0; j < OUT; j++) begin
            logic [2:0] exp_sel;
            exp_sel = 3'(4 - j);
            check($sformatf("par_s%0d", j), sel_o[j], exp_sel);
        end
        drive(5'b00100, 5'b00100, 5'b11111, all_to(3'd7));
        check("oor_g", grant_o, 5'b00000);
        tick();
        check("oor_v", valid_o, 5'b00000);
        check("oor_s2", sel_o[2], 3'd2);

        // Pointer wrap on output 1, then reset in the middle of a packet
        do_reset();
        drive(5'b01000, 5'b01000, 5'b11111, all_to(3'd1));
        check("wr_g0", grant_o, 5'b01000);
        tick();
        check("wr_s0", sel_o[1], 3'd3);
        drive(5'b01001, 5'b01001, 5'b11111, all_to(3'd1));
        check("wr_wrap_g", grant_o, 5'b00001);
        tick();
        check("wr_wrap_s", sel_o[1], 3'd0);
        check("wr_wrap_v", valid_o, 5'b00010);
        drive(5'b01000, 5'b00000, 5'b11111, all_to(3'd1));
        check("wr_head_g", grant_o, 5'b01000);
        tick();
        check("wr_head_v", valid_o, 5'b00010);
        rst = 1'b0;
        #1;
        check("mid_rst_v", valid_o, 5'b00000);
        check("mid_rst_s", sel_o, 15'b0);
        check("mid_rst_g", grant_o, 5'b00000);
        tick();
        rst = 1'b1;
        #1;
        drive(5'b01001, 5'b00001, 5'b11111, all_to(3'd1));
        check("post_mid_rst_g", grant_o, 5'b00001);
        tick();
        check("post_mid_rst_s", sel_o[1], 3'd0);
        check("post_mid_rst_v", valid_o, 5'b00010);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
